// File: rtl/register_file.sv
// Architectural register file with rename tags for an out-of-order core.
// Optional macro RF_COMMIT_BYPASS_EN forwards a same-cycle commit to matching lookups.
module register_file #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clr_in,
   input  logic                 rob_to_rf_ready,
   input  logic [4:0]           rob_to_rf_reg_id,
   input  logic [31:0]          rob_to_rf_reg_val,
   input  logic [ROB_WIDTH-1:0] rob_to_rf_rob_index,
   input  logic                 issue_ready,
   input  logic [4:0]           issue_rd_id,
   input  logic [ROB_WIDTH-1:0] issue_rob_index,
   input  logic [4:0]           iu_rs1_id,
   input  logic [4:0]           iu_rs2_id,
   output logic                 rf_rs1_busy,
   output logic                 rf_rs2_busy,
   output logic [ROB_WIDTH-1:0] rf_rs1_depend,
   output logic [ROB_WIDTH-1:0] rf_rs2_depend,
   output logic [31:0]          rf_rs1_val,
   output logic [31:0]          rf_rs2_val
);

   typedef struct packed {
      logic                 busy;
      logic [ROB_WIDTH-1:0] dep;
      logic [31:0]          val;
   } rd_t;

   logic [31:0]          val_q  [32];
   logic [31:0]          val_d  [32];
   logic                 busy_q [32];
   logic                 busy_d [32];
   logic [ROB_WIDTH-1:0] tag_q  [32];
   logic [ROB_WIDTH-1:0] tag_d  [32];

   logic commit_fire;
   logic rename_fire;
   rd_t  rs1_r;
   rd_t  rs2_r;

   assign commit_fire = rdy_in & rob_to_rf_ready & (rob_to_rf_reg_id != 5'd0);
   assign rename_fire = rdy_in & issue_ready & ~clr_in & (issue_rd_id != 5'd0);

   function automatic rd_t lookup(input logic [4:0] id);
      rd_t r;
      r.busy = busy_q[id];
      r.dep  = busy_q[id] ? tag_q[id] : '0;
      r.val  = val_q[id];
`ifdef RF_COMMIT_BYPASS_EN
      // Only a commit that would actually retire the current producer is forwarded.
      if (commit_fire && (rob_to_rf_reg_id == id) && busy_q[id] &&
          (tag_q[id] == rob_to_rf_rob_index)) begin
         r.busy = 1'b0;
         r.dep  = '0;
         r.val  = rob_to_rf_reg_val;
      end
`endif
      if (id == 5'd0) begin
         r = '0;
      end
      return r;
   endfunction

   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (commit_fire) begin
         val_d[rob_to_rf_reg_id] = rob_to_rf_reg_val;
         // A younger rename may own the register; keep its tag in that case.
         if (tag_q[rob_to_rf_reg_id] == rob_to_rf_rob_index) begin
            busy_d[rob_to_rf_reg_id] = 1'b0;
            tag_d[rob_to_rf_reg_id]  = '0;
         end
      end
      if (rdy_in && clr_in) begin
         for (int i = 0; i < 32; i++) begin
            busy_d[i] = 1'b0;
            tag_d[i]  = '0;
         end
      end else if (rename_fire) begin
         busy_d[issue_rd_id] = 1'b1;
         tag_d[issue_rd_id]  = issue_rob_index;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < 32; i++) begin
            val_q[i]  <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else begin
         val_q  <= val_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

   always_comb begin
      rs1_r         = lookup(iu_rs1_id);
      rs2_r         = lookup(iu_rs2_id);
      rf_rs1_busy   = rs1_r.busy;
      rf_rs1_depend = rs1_r.dep;
      rf_rs1_val    = rs1_r.val;
      rf_rs2_busy   = rs2_r.busy;
      rf_rs2_depend = rs2_r.dep;
      rf_rs2_val    = rs2_r.val;
   end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table plus reset, bypass and rdy sequences.
module tb_register_file;

   localparam int RW = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          rdy_in;
   logic          clr_in;
   logic          rob_to_rf_ready;
   logic [4:0]    rob_to_rf_reg_id;
   logic [31:0]   rob_to_rf_reg_val;
   logic [RW-1:0] rob_to_rf_rob_index;
   logic          issue_ready;
   logic [4:0]    issue_rd_id;
   logic [RW-1:0] issue_rob_index;
   logic [4:0]    iu_rs1_id;
   logic [4:0]    iu_rs2_id;
   logic          rf_rs1_busy;
   logic          rf_rs2_busy;
   logic [RW-1:0] rf_rs1_depend;
   logic [RW-1:0] rf_rs2_depend;
   logic [31:0]   rf_rs1_val;
   logic [31:0]   rf_rs2_val;

   int checks = 0;
   int errors = 0;

   register_file #(.ROB_WIDTH(RW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
      .rob_to_rf_ready(rob_to_rf_ready), .rob_to_rf_reg_id(rob_to_rf_reg_id),
      .rob_to_rf_reg_val(rob_to_rf_reg_val), .rob_to_rf_rob_index(rob_to_rf_rob_index),
      .issue_ready(issue_ready), .issue_rd_id(issue_rd_id), .issue_rob_index(issue_rob_index),
      .iu_rs1_id(iu_rs1_id), .iu_rs2_id(iu_rs2_id),
      .rf_rs1_busy(rf_rs1_busy), .rf_rs2_busy(rf_rs2_busy),
      .rf_rs1_depend(rf_rs1_depend), .rf_rs2_depend(rf_rs2_depend),
      .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic          rdy;
      logic          clr;
      logic          cv;
      logic [4:0]    cid;
      logic [31:0]   cval;
      logic [RW-1:0] cidx;
      logic          iv;
      logic [4:0]    ird;
      logic [RW-1:0] iidx;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic          eb1;
      logic [RW-1:0] ed1;
      logic [31:0]   ev1;
      logic          eb2;
      logic [RW-1:0] ed2;
      logic [31:0]   ev2;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_port(input string tag, input logic b, input logic [RW-1:0] d,
                           input logic [31:0] v, input logic eb, input logic [RW-1:0] ed,
                           input logic [31:0] ev);
      chk({tag, "_busy"}, {31'd0, b}, {31'd0, eb});
      chk({tag, "_dep"}, {28'd0, d}, {28'd0, ed});
      chk({tag, "_val"}, v, ev);
   endtask

   task automatic idle();
      rdy_in = 1'b1; clr_in = 1'b0;
      rob_to_rf_ready = 1'b0; rob_to_rf_reg_id = 5'd0; rob_to_rf_reg_val = 32'd0;
      rob_to_rf_rob_index = '0;
      issue_ready = 1'b0; issue_rd_id = 5'd0; issue_rob_index = '0;
   endtask

   task automatic drive(input vec_t v);
      rdy_in = v.rdy; clr_in = v.clr;
      rob_to_rf_ready = v.cv; rob_to_rf_reg_id = v.cid; rob_to_rf_reg_val = v.cval;
      rob_to_rf_rob_index = v.cidx;
      issue_ready = v.iv; issue_rd_id = v.ird; issue_rob_index = v.iidx;
      iu_rs1_id = v.rs1; iu_rs2_id = v.rs2;
   endtask

   initial begin
      // Fields: rdy clr cv cid cval cidx iv ird iidx rs1 rs2 | eb1 ed1 ev1 eb2 ed2 ev2
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b1,5'd0,4'd3,5'd5,5'd0, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b1,5'd5,4'd2,5'd0,5'd5, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b1,5'd7,4'd2,5'd5,5'd0, 1'b1,4'd2,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b1,5'd7,4'd4,5'd7,5'd5, 1'b1,4'd2,32'h0, 1'b1,4'd2,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b1,5'd7,32'h11,4'd2,1'b0,5'd0,4'd0,5'd7,5'd5, 1'b1,4'd4,32'h0, 1'b1,4'd2,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b0,5'd0,4'd0,5'd7,5'd7, 1'b1,4'd4,32'h11, 1'b1,4'd4,32'h11});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b1,5'd9,32'h22,4'd1,1'b1,5'd9,4'd6,5'd9,5'd0, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b1,5'd1,4'd1,5'd9,5'd7, 1'b1,4'd6,32'h22, 1'b1,4'd4,32'h11});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b1,5'd2,4'd2,5'd1,5'd2, 1'b1,4'd1,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b1,5'd3,4'd3,5'd2,5'd3, 1'b1,4'd2,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b1,1'b1,5'd1,32'h33,4'd1,1'b1,5'd4,4'd4,5'd3,5'd4, 1'b1,4'd3,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b0,5'd0,4'd0,5'd1,5'd4, 1'b0,4'd0,32'h33, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b0,5'd0,4'd0,5'd5,5'd7, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h11});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b0,5'd0,4'd0,5'd2,5'd9, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h22});
      vecs.push_back(vec_t'{1'b0,1'b0,1'b1,5'd2,32'h55,4'd0,1'b1,5'd3,4'd5,5'd2,5'd3, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b0,5'd0,4'd0,5'd2,5'd3, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b1,5'd31,4'd15,5'd31,5'd0, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b0,5'd0,4'd0,5'd31,5'd30, 1'b1,4'd15,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b1,5'd31,32'hFFFFFFFF,4'd15,1'b0,5'd0,4'd0,5'd0,5'd30, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b1,5'd0,32'h77,4'd0,1'b1,5'd0,4'd9,5'd31,5'd31, 1'b0,4'd0,32'hFFFFFFFF, 1'b0,4'd0,32'hFFFFFFFF});
      vecs.push_back(vec_t'{1'b1,1'b0,1'b0,5'd0,32'h0,4'd0,1'b0,5'd0,4'd0,5'd0,5'd0, 1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0});

      rst_in = 1'b0;
      idle();
      iu_rs1_id = 5'd5; iu_rs2_id = 5'd0;
      repeat (2) @(negedge clk_in);
      #1;
      chk_port("reset_rs1", rf_rs1_busy, rf_rs1_depend, rf_rs1_val, 1'b0, 4'd0, 32'h0);
      chk_port("reset_rs2", rf_rs2_busy, rf_rs2_depend, rf_rs2_val, 1'b0, 4'd0, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_in);
         drive(vecs[i]);
         #1;
         chk_port($sformatf("v%0d_rs1", i), rf_rs1_busy, rf_rs1_depend, rf_rs1_val,
                  vecs[i].eb1, vecs[i].ed1, vecs[i].ev1);
         chk_port($sformatf("v%0d_rs2", i), rf_rs2_busy, rf_rs2_depend, rf_rs2_val,
                  vecs[i].eb2, vecs[i].ed2, vecs[i].ev2);
      end

      // Same-cycle commit visibility on a busy register with a matching tag.
      @(negedge clk_in);
      idle();
      issue_ready = 1'b1; issue_rd_id = 5'd5; issue_rob_index = 4'd2;
      iu_rs1_id = 5'd5; iu_rs2_id = 5'd5;
      @(negedge clk_in);
      idle();
      rob_to_rf_ready = 1'b1; rob_to_rf_reg_id = 5'd5; rob_to_rf_reg_val = 32'hDEADBEEF;
      rob_to_rf_rob_index = 4'd2;
      #1;
`ifdef RF_COMMIT_BYPASS_EN
      chk_port("byp_same", rf_rs1_busy, rf_rs1_depend, rf_rs1_val, 1'b0, 4'd0, 32'hDEADBEEF);
`else
      chk_port("byp_same", rf_rs1_busy, rf_rs1_depend, rf_rs1_val, 1'b1, 4'd2, 32'h0);
`endif
      @(negedge clk_in);
      idle();
      #1;
      chk_port("byp_next", rf_rs2_busy, rf_rs2_depend, rf_rs2_val, 1'b0, 4'd0, 32'hDEADBEEF);

      // Reset dropped mid-cycle clears everything before the next edge.
      @(negedge clk_in);
      issue_ready = 1'b1; issue_rd_id = 5'd10; issue_rob_index = 4'd3;
      rob_to_rf_ready = 1'b1; rob_to_rf_reg_id = 5'd11; rob_to_rf_reg_val = 32'hA5A5A5A5;
      @(negedge clk_in);
      idle();
      iu_rs1_id = 5'd10; iu_rs2_id = 5'd11;
      #1;
      chk_port("pre_rst_rs1", rf_rs1_busy, rf_rs1_depend, rf_rs1_val, 1'b1, 4'd3, 32'h0);
      chk_port("pre_rst_rs2", rf_rs2_busy, rf_rs2_depend, rf_rs2_val, 1'b0, 4'd0, 32'hA5A5A5A5);
      issue_ready = 1'b1; issue_rd_id = 5'd12; issue_rob_index = 4'd7;
      #1;
      rst_in = 1'b0;
      #1;
      chk_port("mid_rst_rs1", rf_rs1_busy, rf_rs1_depend, rf_rs1_val, 1'b0, 4'd0, 32'h0);
      chk_port("mid_rst_rs2", rf_rs2_busy, rf_rs2_depend, rf_rs2_val, 1'b0, 4'd0, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;
      idle();
      issue_ready = 1'b1; issue_rd_id = 5'd13; issue_rob_index = 4'd1;
      iu_rs1_id = 5'd12; iu_rs2_id = 5'd5;
      @(negedge clk_in);
      idle();
      iu_rs1_id = 5'd12; iu_rs2_id = 5'd13;
      #1;
      chk_port("post_rst_rs1", rf_rs1_busy, rf_rs1_depend, rf_rs1_val, 1'b0, 4'd0, 32'h0);
      chk_port("post_rst_rs2", rf_rs2_busy, rf_rs2_depend, rf_rs2_val, 1'b1, 4'd1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
